// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly, three-stage pipeline with valid/ready handshake.
// y0 = a + W*b, y1 = a - W*b, rounded half-up and saturated.
module fft_butterfly #(
   parameter int WIDTH    = 12,
   parameter int FRACTION = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_re,
   input  logic [WIDTH-1:0] a_im,
   input  logic [WIDTH-1:0] b_re,
   input  logic [WIDTH-1:0] b_im,
   input  logic [1:0]       tw_sel,
   output logic [1:0]       rom_addr,
   input  logic [WIDTH-1:0] w_re,
   input  logic [WIDTH-1:0] w_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y0_re,
   output logic [WIDTH-1:0] y0_im,
   output logic [WIDTH-1:0] y1_re,
   output logic [WIDTH-1:0] y1_im,
   output logic             sat
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = PW + 1;
   localparam int YW = SW + 2;

   localparam logic [SW:0] RND =
      {{(SW + 1 - FRACTION){1'b0}}, 1'b1, {(FRACTION - 1){1'b0}}};
   localparam logic [YW-1:0] YMAX =
      {{(YW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic [YW-1:0] YMIN =
      {{(YW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   // Full-precision signed product of two WIDTH-bit words.
   function automatic logic [PW-1:0] mul(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      logic signed [PW-1:0] xs;
      logic signed [PW-1:0] ys;
      xs = $signed({{WIDTH{x[WIDTH-1]}}, x});
      ys = $signed({{WIDTH{y[WIDTH-1]}}, y});
      return xs * ys;
   endfunction

   // Add half an LSB, then drop the fraction with an arithmetic shift.
   function automatic logic [SW:0] rnd(input logic [SW-1:0] p);
      logic [SW:0] s;
      s = {p[SW-1], p} + RND;
      return $signed(s) >>> FRACTION;
   endfunction

   // Wide sum plus twiddled term, sign-extended to YW bits.
   function automatic logic [YW-1:0] addsub(
      input logic [WIDTH-1:0] a,
      input logic [SW:0]      t,
      input logic             sub
   );
      logic [YW-1:0] ae;
      logic [YW-1:0] te;
      ae = {{(YW - WIDTH){a[WIDTH-1]}}, a};
      te = {t[SW], t};
      return sub ? (ae - te) : (ae + te);
   endfunction

   // Clamp to WIDTH bits; MSB of the result flags a clamp event.
   function automatic logic [WIDTH:0] clamp(input logic [YW-1:0] v);
      logic [WIDTH:0] r;
      if ($signed(v) > $signed(YMAX)) begin
         r = {1'b1, 1'b0, {(WIDTH - 1){1'b1}}};
      end else if ($signed(v) < $signed(YMIN)) begin
         r = {1'b1, 1'b1, {(WIDTH - 1){1'b0}}};
      end else begin
         r = {1'b0, v[WIDTH-1:0]};
      end
      return r;
   endfunction

   logic             en;

   logic             v1_q;
   logic [WIDTH-1:0] a1_re_q, a1_im_q;
   logic [WIDTH-1:0] b1_re_q, b1_im_q;
   logic [WIDTH-1:0] w1_re_q, w1_im_q;

   logic             v2_q;
   logic [WIDTH-1:0] a2_re_q, a2_im_q;
   logic [PW-1:0]    prr_q, pii_q, pri_q, pir_q;
   logic [PW-1:0]    prr_d, pii_d, pri_d, pir_d;

   logic             v3_q;
   logic [WIDTH-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
   logic [WIDTH-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
   logic             sat_q, sat_d;

   logic [SW-1:0]    p_re, p_im;
   logic [SW:0]      t_re, t_im;
   logic             s0r, s0i, s1r, s1i;

   assign en        = !(v3_q && !out_ready);
   assign in_ready  = en;
   assign rom_addr  = tw_sel;
   assign out_valid = v3_q;
   assign y0_re     = y0_re_q;
   assign y0_im     = y0_im_q;
   assign y1_re     = y1_re_q;
   assign y1_im     = y1_im_q;
   assign sat       = sat_q;

   // S1: capture operands and the twiddle returned for rom_addr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         a1_re_q <= '0;
         a1_im_q <= '0;
         b1_re_q <= '0;
         b1_im_q <= '0;
         w1_re_q <= '0;
         w1_im_q <= '0;
      end else if (en) begin
         v1_q    <= in_valid;
         a1_re_q <= a_re;
         a1_im_q <= a_im;
         b1_re_q <= b_re;
         b1_im_q <= b_im;
         w1_re_q <= w_re;
         w1_im_q <= w_im;
      end
   end

   // S2 next state: the four partial products of W*b.
   always_comb begin
      prr_d = mul(b1_re_q, w1_re_q);
      pii_d = mul(b1_im_q, w1_im_q);
      pri_d = mul(b1_re_q, w1_im_q);
      pir_d = mul(b1_im_q, w1_re_q);
   end

   // S2: register products and carry a forward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         a2_re_q <= '0;
         a2_im_q <= '0;
         prr_q   <= '0;
         pii_q   <= '0;
         pri_q   <= '0;
         pir_q   <= '0;
      end else if (en) begin
         v2_q    <= v1_q;
         a2_re_q <= a1_re_q;
         a2_im_q <= a1_im_q;
         prr_q   <= prr_d;
         pii_q   <= pii_d;
         pri_q   <= pri_d;
         pir_q   <= pir_d;
      end
   end

   // S3 next state: combine, round, add/subtract and saturate.
   always_comb begin
      p_re = {prr_q[PW-1], prr_q} - {pii_q[PW-1], pii_q};
      p_im = {pri_q[PW-1], pri_q} + {pir_q[PW-1], pir_q};
      t_re = rnd(p_re);
      t_im = rnd(p_im);
      {s0r, y0_re_d} = clamp(addsub(a2_re_q, t_re, 1'b0));
      {s0i, y0_im_d} = clamp(addsub(a2_im_q, t_im, 1'b0));
      {s1r, y1_re_d} = clamp(addsub(a2_re_q, t_re, 1'b1));
      {s1i, y1_im_d} = clamp(addsub(a2_im_q, t_im, 1'b1));
      sat_d = s0r | s0i | s1r | s1i;
   end

   // S3: output register, held while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q    <= 1'b0;
         y0_re_q <= '0;
         y0_im_q <= '0;
         y1_re_q <= '0;
         y1_im_q <= '0;
         sat_q   <= 1'b0;
      end else if (en) begin
         v3_q    <= v2_q;
         y0_re_q <= y0_re_d;
         y0_im_q <= y0_im_d;
         y1_re_q <= y1_re_d;
         y1_im_q <= y1_im_d;
         sat_q   <= sat_d;
      end
   end

endmodule
